// File: rtl/recurse_mux_arb.sv
// recurse_mux_arb: round-robin N:1 collector with packet locking and a registered output stage.
// out_sel carries the source lane so a downstream demux can route beats back.
module recurse_mux_arb #(
    parameter int S = 2,
    parameter int T = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [(2**S)*T-1:0]  in_data,
    input  logic [2**S-1:0]      in_valid,
    input  logic [2**S-1:0]      in_last,
    output logic [2**S-1:0]      in_ready,
    output logic [T-1:0]         out_data,
    output logic [S-1:0]         out_sel,
    output logic                 out_last,
    output logic                 out_valid,
    input  logic                 out_ready
);
    localparam int N = 2**S;
    typedef enum logic {ARB, LOCKED} state_t;
    state_t       state_q;
    logic [S-1:0] ptr_q, lk_q, cand, idx, g;
    logic         found, load, xfer, locked;
    assign load   = ~out_valid | out_ready;
    assign locked = (state_q == LOCKED);
    // Rotating-priority search; ptr wraps naturally as an S-bit sum.
    always_comb begin
        found = 1'b0;
        cand  = ptr_q;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = ptr_q + S'(k);
            if (!found && in_valid[idx]) begin
                found = 1'b1;
                cand  = idx;
            end
        end
        g        = locked ? lk_q : cand;
        in_ready = (reset || !load || (!locked && !found)) ? '0 : N'(1) << g;
        xfer     = in_valid[g] & in_ready[g];
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ARB;
            ptr_q     <= '0;
            lk_q      <= '0;
            out_data  <= '0;
            out_sel   <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= xfer;
            if (xfer) begin
                out_data <= in_data[g*T +: T];
                out_sel  <= g;
                out_last <= in_last[g];
                state_q  <= in_last[g] ? ARB : LOCKED;
                lk_q     <= g;
                if (in_last[g])
                    ptr_q <= g + S'(1);
            end
        end
    end
endmodule

// File: tb/tb_recurse_mux_arb.sv
// tb_recurse_mux_arb: directed plan plus random traffic, checked every cycle against a lane-level model.
module tb_recurse_mux_arb;
    localparam int S = 2;
    localparam int T = 1;
    localparam int N = 4;
    logic             clk = 1'b0;
    logic             reset;
    logic [N*T-1:0]   in_data;
    logic [N-1:0]     in_valid, in_last, in_ready;
    logic [T-1:0]     out_data;
    logic [S-1:0]     out_sel;
    logic             out_last, out_valid, out_ready;
    int checks = 0;
    int errors = 0;
    // Reference state: who owns the output, and the beat currently presented downstream.
    int         m_ptr, m_lk, m_sel;
    bit         m_locked, m_last, m_valid;
    logic [T-1:0] m_data;
    always #5 clk = ~clk;
    recurse_mux_arb #(.S(S), .T(T)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .out_data(out_data),
        .out_sel(out_sel), .out_last(out_last), .out_valid(out_valid),
        .out_ready(out_ready)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    function automatic logic [N-1:0] exp_ready();
        int lane;
        if (reset || (m_valid && !out_ready)) return '0;
        if (m_locked) return N'(1) << m_lk;
        for (int i = 0; i < N; i++) begin
            lane = (m_ptr + i) % N;
            if (in_valid[lane]) return N'(1) << lane;
        end
        return '0;
    endfunction
    task automatic step();
        logic [N-1:0] er;
        int lane;
        @(negedge clk);
        er = exp_ready();
        chk("in_ready", 32'(in_ready), 32'(er));
        chk("ready_onehot", 32'($countones(in_ready) <= 1), 32'd1);
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_sel", 32'(out_sel), 32'(m_sel));
        chk("out_data", 32'(out_data), 32'(m_data));
        chk("out_last", 32'(out_last), 32'(m_last));
        lane = -1;
        for (int i = 0; i < N; i++) if (er[i] && in_valid[i]) lane = i;
        if (reset) begin
            m_ptr = 0; m_lk = 0; m_locked = 0; m_sel = 0; m_last = 0; m_valid = 0; m_data = '0;
        end else if (!m_valid || out_ready) begin
            m_valid = (lane >= 0);
            if (lane >= 0) begin
                m_sel  = lane;
                m_data = in_data[lane*T +: T];
                m_last = in_last[lane];
                m_locked = !in_last[lane];
                if (in_last[lane]) m_ptr = (lane + 1) % N;
                else m_lk = lane;
            end
        end
        @(posedge clk);
        #1;
    endtask
    initial begin
        m_ptr = 0; m_lk = 0; m_sel = 0; m_locked = 0; m_last = 0; m_valid = 0; m_data = '0;
        reset = 1'b1; in_valid = '1; in_last = '1; in_data = '0; out_ready = 1'b1;
        // Reset held with every lane requesting.
        step();
        step();
        reset = 1'b0; in_data = 4'b1010;
        // Round-robin across all lanes with single-beat packets.
        for (int k = 0; k < 5; k++) begin
            step();
            chk("rr_sel", 32'(out_sel), 32'(k % 4));
            chk("rr_data", 32'(out_data), 32'(k % 2));
        end
        // Lane 2 sends a 3-beat packet while lanes 0 and 3 wait.
        in_valid = 4'b1101; in_last = 4'b1011;
        step(); chk("lock_sel0", 32'(out_sel), 32'd2);
        step(); chk("lock_sel1", 32'(out_sel), 32'd2);
        in_last = 4'b1111;
        step(); chk("lock_sel2", 32'(out_sel), 32'd2);
        in_valid = 4'b1001;
        step(); chk("after_lock_sel", 32'(out_sel), 32'd3);
        step(); chk("after_lock_sel2", 32'(out_sel), 32'd0);
        // Backpressure mid-stream.
        in_valid = 4'b1111; in_data = 4'b0110;
        step();
        out_ready = 1'b0;
        repeat (3) step();
        out_ready = 1'b1;
        repeat (3) step();
        // Wrap with sparse requests, then an idle cycle.
        in_valid = 4'b0100;
        step(); chk("sparse_sel2", 32'(out_sel), 32'd2);
        in_valid = 4'b0010;
        step(); chk("wrap_sel1", 32'(out_sel), 32'd1);
        in_valid = 4'b0000;
        step(); chk("idle_valid", 32'(out_valid), 32'd0);
        in_valid = 4'b1110;
        step(); chk("ptr_after_wrap", 32'(out_sel), 32'd2);
        // Reset while locked on lane 1.
        in_valid = 4'b0010; in_last = 4'b0000;
        step(); step();
        reset = 1'b1; in_valid = 4'b1111;
        step(); chk("rst_mid_valid", 32'(out_valid), 32'd0);
        reset = 1'b0; in_last = 4'b1111;
        step(); chk("rst_mid_sel", 32'(out_sel), 32'd0);
        // Random traffic.
        for (int c = 0; c < 500; c++) begin
            in_valid  = N'($urandom);
            in_last   = N'($urandom_range(0, 15)) | N'($urandom);
            in_data   = (N*T)'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            reset     = ($urandom_range(0, 63) == 0);
            step();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
